// File: rtl/piece_drop_ctrl.sv
// Connect-4 draw sequencer: cursor, column heights, current player and board wipe, one drawer request at a time.
// Optional macro WRAP_CURSOR_EN makes left/right wrap around the board edges instead of saturating.
module piece_drop_ctrl #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       left,
  input  logic       right,
  input  logic       drop,
  input  logic       clear_req,
  input  logic       draw_complete,
  output logic       draw_enable,
  output logic [2:0] draw_column,
  output logic [2:0] draw_row,
  output logic       draw_player,
  output logic       draw_reset_game,
  output logic       cur_player,
  output logic       busy,
  output logic       col_full,
  output logic       board_full
);

  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
  localparam logic [2:0] ROWS3    = 3'(NUM_ROWS);
  localparam logic [5:0] CELLS    = 6'(NUM_COLS * NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR_REQ, S_CLEAR_GAP, S_CURSOR_REQ, S_DROP_REQ, S_GAP
  } state_t;

  state_t     r_state;
  logic [2:0] r_cursor;
  logic [2:0] r_heights [0:NUM_COLS-1];
  logic [5:0] r_filled;
  logic [2:0] r_clr_row;
  logic [2:0] r_clr_col;
  logic       r_clr_last;
  logic       r_gap_cursor;
  logic       r_draw_enable;
  logic [2:0] r_draw_column;
  logic [2:0] r_draw_row;
  logic       r_draw_player;
  logic       r_draw_reset_game;
  logic       r_cur_player;
  logic       r_busy;
  logic       r_col_full;
  logic       r_board_full;

  logic [2:0] w_left_col;
  logic [2:0] w_right_col;
  logic       w_left_move;
  logic       w_right_move;
  logic [2:0] w_cur_h;
  logic       w_col_is_full;
  logic [2:0] w_issue_row;
  logic [2:0] w_issue_col;
  logic       w_issue_last;
  logic [2:0] w_next_row;
  logic [2:0] w_next_col;

`ifdef WRAP_CURSOR_EN
  assign w_left_col   = (r_cursor == 3'd0) ? LAST_COL : r_cursor - 3'd1;
  assign w_right_col  = (r_cursor == LAST_COL) ? 3'd0 : r_cursor + 3'd1;
  assign w_left_move  = 1'b1;
  assign w_right_move = 1'b1;
`else
  assign w_left_col   = (r_cursor == 3'd0) ? 3'd0 : r_cursor - 3'd1;
  assign w_right_col  = (r_cursor == LAST_COL) ? LAST_COL : r_cursor + 3'd1;
  assign w_left_move  = (r_cursor != 3'd0);
  assign w_right_move = (r_cursor != LAST_COL);
`endif

  assign w_cur_h       = r_heights[r_cursor];
  assign w_col_is_full = (w_cur_h == ROWS3) || r_board_full;

  // A wipe started from IDLE always begins at cell (1,0); otherwise the wipe counter holds the next cell.
  assign w_issue_row  = (r_state == S_IDLE) ? 3'd1 : r_clr_row;
  assign w_issue_col  = (r_state == S_IDLE) ? 3'd0 : r_clr_col;
  assign w_issue_last = (w_issue_row == ROWS3) && (w_issue_col == LAST_COL);
  assign w_next_col   = (w_issue_col == LAST_COL) ? 3'd0 : w_issue_col + 3'd1;
  assign w_next_row   = (w_issue_col == LAST_COL) ? w_issue_row + 3'd1 : w_issue_row;

  // Sequencer FSM; resets into CLEAR_GAP so the first edge after release starts the wipe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state           <= S_CLEAR_GAP;
      r_cursor          <= 3'd0;
      for (int i = 0; i < NUM_COLS; i++) r_heights[i] <= 3'd0;
      r_filled          <= 6'd0;
      r_clr_row         <= 3'd1;
      r_clr_col         <= 3'd0;
      r_clr_last        <= 1'b0;
      r_gap_cursor      <= 1'b0;
      r_draw_enable     <= 1'b0;
      r_draw_column     <= 3'd0;
      r_draw_row        <= 3'd0;
      r_draw_player     <= 1'b0;
      r_draw_reset_game <= 1'b0;
      r_cur_player      <= 1'b0;
      r_busy            <= 1'b0;
      r_col_full        <= 1'b0;
      r_board_full      <= 1'b0;
    end else begin
      r_col_full <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state           <= S_CLEAR_REQ;
            r_draw_enable     <= 1'b1;
            r_draw_row        <= w_issue_row;
            r_draw_column     <= w_issue_col;
            r_draw_player     <= 1'b0;
            r_draw_reset_game <= 1'b1;
            r_clr_row         <= w_next_row;
            r_clr_col         <= w_next_col;
            r_clr_last        <= w_issue_last;
            r_busy            <= 1'b1;
          end else if (drop) begin
            if (w_col_is_full) begin
              r_col_full <= 1'b1;
            end else begin
              r_state           <= S_DROP_REQ;
              r_draw_enable     <= 1'b1;
              r_draw_row        <= ROWS3 - w_cur_h;
              r_draw_column     <= r_cursor;
              r_draw_player     <= r_cur_player;
              r_draw_reset_game <= 1'b0;
              r_busy            <= 1'b1;
            end
          end else if ((left && !right && w_left_move) || (right && !left && w_right_move)) begin
            r_cursor          <= left ? w_left_col : w_right_col;
            r_state           <= S_CURSOR_REQ;
            r_draw_enable     <= 1'b1;
            r_draw_row        <= 3'd0;
            r_draw_column     <= left ? w_left_col : w_right_col;
            r_draw_player     <= r_cur_player;
            r_draw_reset_game <= 1'b0;
            r_busy            <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CLEAR_REQ: begin
          if (draw_complete) begin
            r_state       <= S_CLEAR_GAP;
            r_draw_enable <= 1'b0;
            if (r_clr_last) begin
              for (int i = 0; i < NUM_COLS; i++) r_heights[i] <= 3'd0;
              r_filled     <= 6'd0;
              r_cur_player <= 1'b0;
              r_cursor     <= 3'd0;
              r_board_full <= 1'b0;
            end
          end
        end
        S_CLEAR_GAP: begin
          r_busy        <= 1'b1;
          r_draw_enable <= 1'b1;
          if (r_clr_last) begin
            r_clr_last        <= 1'b0;
            r_state           <= S_CURSOR_REQ;
            r_draw_row        <= 3'd0;
            r_draw_column     <= r_cursor;
            r_draw_player     <= r_cur_player;
            r_draw_reset_game <= 1'b0;
          end else begin
            r_state           <= S_CLEAR_REQ;
            r_draw_row        <= w_issue_row;
            r_draw_column     <= w_issue_col;
            r_draw_player     <= 1'b0;
            r_draw_reset_game <= 1'b1;
            r_clr_row         <= w_next_row;
            r_clr_col         <= w_next_col;
            r_clr_last        <= w_issue_last;
          end
        end
        S_CURSOR_REQ: begin
          if (draw_complete) begin
            r_state       <= S_GAP;
            r_draw_enable <= 1'b0;
            r_gap_cursor  <= 1'b0;
          end
        end
        S_DROP_REQ: begin
          if (draw_complete) begin
            r_state             <= S_GAP;
            r_draw_enable       <= 1'b0;
            r_heights[r_cursor] <= w_cur_h + 3'd1;
            r_filled            <= r_filled + 6'd1;
            r_board_full        <= (r_filled + 6'd1 == CELLS);
            r_cur_player        <= ~r_cur_player;
            r_gap_cursor        <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cursor) begin
            r_gap_cursor      <= 1'b0;
            r_state           <= S_CURSOR_REQ;
            r_draw_enable     <= 1'b1;
            r_draw_row        <= 3'd0;
            r_draw_column     <= r_cursor;
            r_draw_player     <= r_cur_player;
            r_draw_reset_game <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_draw_enable <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign draw_enable     = r_draw_enable;
  assign draw_column     = r_draw_column;
  assign draw_row        = r_draw_row;
  assign draw_player     = r_draw_player;
  assign draw_reset_game = r_draw_reset_game;
  assign cur_player      = r_cur_player;
  assign busy            = r_busy;
  assign col_full        = r_col_full;
  assign board_full      = r_board_full;

endmodule

// File: doc/piece_drop_ctrl.md
Name: piece_drop_ctrl

Overview:
- Upstream sequencer for the cell-drawing stage of the Connect-4 board.
- Owns the column cursor, per-column stack heights and the current player; turns single-cycle user pulses (left, right, drop, clear) into one draw request at a time.
- Drives the drawer's column/row/enable/player/resetGame inputs and waits for its drawComplete.
- Row 0 is the selector row above the board. Board rows are 1..NUM_ROWS, with NUM_ROWS at the bottom.

Parameters:
- NUM_COLS, 7, number of board columns (cursor range 0..NUM_COLS-1; max 8).
- NUM_ROWS, 6, number of board rows (pieces occupy rows 1..NUM_ROWS; max 7).

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- left  in  1  one-cycle pulse: move cursor left.
- right  in  1  one-cycle pulse: move cursor right.
- drop  in  1  one-cycle pulse: drop current player's piece in cursor column.
- clear_req  in  1  one-cycle pulse: wipe board, restart game.
- draw_complete  in  1  drawer done flag; held high while draw_enable is held.
- draw_enable  out  1  request to drawer; held until draw_complete.
- draw_column  out  3  column of current request.
- draw_row  out  3  row of current request (0 = selector row).
- draw_player  out  1  colour select (1 = red, 0 = yellow).
- draw_reset_game  out  1  high during board wipe, so board cells draw white.
- cur_player  out  1  player to move.
- busy  out  1  high in any state other than IDLE.
- col_full  out  1  one-cycle pulse when a drop targets a full column.
- board_full  out  1  high once all NUM_COLS*NUM_ROWS cells are occupied.

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0; cursor=0; all heights=0; cur_player=0.
  - FSM enters CLEAR_REQ on release, so the screen is wiped automatically.
- States: IDLE, CLEAR_REQ, CLEAR_GAP, CURSOR_REQ, DROP_REQ, GAP.
- Handshake with the drawer:
  - In any *_REQ state, draw_enable=1 with column/row/player/reset_game stable.
  - Exit on the first cycle draw_complete=1.
  - Next cycle draw_enable=0 (GAP or CLEAR_GAP) for exactly one cycle so the drawer re-initialises.
  - Outputs must not change while draw_enable=1.
- IDLE input priority: clear_req > drop > left/right.
  - left and right together: ignored.
  - Any input arriving while busy=1 is discarded, not queued.
- left/right:
  - cursor -/+1, saturating at 0 and NUM_COLS-1.
  - At a boundary with no change, stay in IDLE and issue no draw.
  - Otherwise go to CURSOR_REQ: row 0, column = new cursor, player = cur_player.
- drop:
  - If heights[cursor]==NUM_ROWS: pulse col_full for 1 cycle, stay IDLE.
  - Otherwise go to DROP_REQ with row = NUM_ROWS - heights[cursor] and draw_reset_game=0.
  - On completion: heights[cursor]+1, toggle cur_player.
  - Then GAP → CURSOR_REQ, which redraws the selector in the new player's colour → GAP → IDLE.
- clear_req and post-reset wipe:
  - Iterate row 1..NUM_ROWS (outer) and column 0..NUM_COLS-1 (inner), issuing CLEAR_REQ for each cell with draw_reset_game=1, each separated by CLEAR_GAP.
  - After the last cell: heights=0, cur_player=0, cursor=0, board_full=0.
  - Then CURSOR_REQ → GAP → IDLE.
- board_full:
  - Set when the sum of heights reaches NUM_COLS*NUM_ROWS; cleared only by a wipe.
  - While high, drop always produces col_full.
- Latency, IDLE pulse to draw_enable: 1 cycle.
- Width rules: heights are 3-bit; row computation is 3-bit unsigned with no underflow possible (guarded by the full check).
- Reset mid-request: draw_enable drops asynchronously and the wipe restarts from cell (1,0).

Optional Feature:
- Macro: WRAP_CURSOR_EN.
- Defined: left at column 0 goes to NUM_COLS-1, and right at NUM_COLS-1 goes to 0. Both issue CURSOR_REQ.
- Undefined: saturating cursor as in Behaviour, with no draw at the boundary.

Test Plan:
- Release resetn → 42 CLEAR_REQ handshakes with draw_reset_game=1 in order (1,0),(1,1)…(6,6), then one cursor request (row 0, col 0, player 0); busy falls; draw_enable low ≥1 cycle between requests.
- drop at cursor 0 twice → requests (row 6, col 0, player 0) then (row 5, col 0, player 1); cur_player 0→1→0; each followed by a row-0 cursor redraw.
- 6 drops in column 3, then a 7th → 7th gives col_full pulse for 1 cycle, no draw_enable, cur_player unchanged.
- left at cursor 0 → no request (without WRAP_CURSOR_EN); with WRAP_CURSOR_EN → cursor request column 6.
- right pulse while busy=1 during a drop draw → ignored; cursor unchanged after IDLE.
- resetn low while draw_enable=1 mid-drop → draw_enable=0 immediately, heights cleared, full wipe replays; fill all 42 cells → board_full=1.
